sensor_cmd_controller: RTL and testbench
========================================

Name: sensor_cmd_controller

Overview:
- Command sequencer between the UART receiver and the sensor interface / UART transmitter.
- Collects 2-byte command frames {command, sensor address} from the receiver's byte strobe and validates them.
- Issues one sensor request per frame, waits for completion or timeout, then schedules a 2-byte response to the transmitter.
- Owns the sensor interface; only one transaction is in flight at any time.

Parameters:
- MAX_ADDR, 31, highest valid sensor address; addresses above it are rejected.
- FRAME_TIMEOUT, 115200, cycles allowed between command byte and address byte (1 s at 115200 Hz).
- SENSOR_TIMEOUT, 230400, cycles allowed from sensor_req rise to sensor_done.

Ports:
- clk_115200hz  in  1  system clock, same domain as the receiver.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid when rx_control is high.
- rx_control  in  1  receiver byte-ready level; may stay high for several cycles.
- sensor_req  out  1  request to the sensor interface; held until sensor_done.
- sensor_addr  out  5  target sensor; stable while sensor_req is high.
- sensor_done  in  1  one-cycle completion pulse.
- sensor_error  in  1  qualifies sensor_done; sensor did not respond or checksum failed.
- sensor_temp  in  8  temperature integer part; valid with sensor_done.
- sensor_hum  in  8  humidity integer part; valid with sensor_done.
- tx_data  out  8  response byte to the transmitter.
- tx_valid  out  1  byte offered; held until accepted.
- tx_ready  in  1  transmitter accepts when tx_valid and tx_ready are both high.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; a byte arrived while the frame could not take it.

Behaviour:
- Reset, asynchronous: state=IDLE; sensor_req=0; sensor_addr=0; tx_valid=0; tx_data=0x00; busy=0; overrun=0; timers=0; edge register=0.
- Reset mid-operation aborts everything immediately. No partial response is completed after reset releases.
- Byte detection: rx_pulse = rx_control & ~rx_control_q, registered edge detect. One byte per rising edge of rx_control.
- Command map:
  - 0x00 status: response {0x08,0x00} on success.
  - 0x01 temperature: response {0x09,sensor_temp}.
  - 0x02 humidity: response {0x0A,sensor_hum}.
  - Any other value is invalid.
- Error responses:
  - sensor_error: {0x1F,0x00}.
  - Invalid command: {0xEF,0x00}.
  - Address above MAX_ADDR: {0xDF,0x00}.
  - Sensor timeout: {0xFE,0x00}.
- IDLE:
  - On rx_pulse: latch cmd=rx_data, clear frame timer, go to GET_ADDR.
- GET_ADDR:
  - Frame timer increments every cycle.
  - On rx_pulse: latch addr.
    - Invalid command: load the invalid-command response, go to SEND0. The command check has priority over the address check.
    - Else if addr > MAX_ADDR: load the bad-address response, go to SEND0.
    - Else: go to REQ.
  - Timer reaches FRAME_TIMEOUT-1 with no rx_pulse: discard the frame, go to IDLE, send no response.
  - rx_pulse on the expiry cycle: the byte is accepted.
- REQ, one cycle:
  - sensor_addr=addr[4:0], sensor_req=1, sensor timer cleared, go to WAIT.
  - sensor_req is high from the cycle after REQ is entered.
- WAIT:
  - sensor_req held; sensor timer increments.
  - On sensor_done: sensor_req=0 next cycle; load the response per the command map (sensor_error overrides the command map); go to SEND0.
  - Timer reaches SENSOR_TIMEOUT-1 without sensor_done: sensor_req=0, load the timeout response, go to SEND0.
  - sensor_done and timeout on the same cycle: sensor_done wins.
- SEND0: tx_valid=1, tx_data=byte0. On tx_valid & tx_ready, go to SEND1.
- SEND1: tx_valid=1, tx_data=byte1. On accept: tx_valid=0, go to IDLE.
- tx_data never changes while tx_valid is high and not accepted.
- tx_ready held high: one byte accepted per cycle, so SEND0→SEND1→IDLE takes 2 cycles.
- rx_pulse in REQ/WAIT/SEND0/SEND1: byte dropped, overrun set to 1. It stays set until reset.
- Timers are 18-bit counters that saturate, never wrap. SENSOR_TIMEOUT must be ≤ 2^18.

Test Plan:
- Reset values: reset asserted mid-WAIT with sensor_req=1 → sensor_req, busy and tx_valid drop within the same cycle; after release the block is in IDLE.
- Temperature read: rx bytes 0x01, 0x03 (rx_control held 3 cycles each) → sensor_addr=3 and sensor_req high for one transaction. Then sensor_done with temp=0x19 → tx 0x09, 0x19. Exactly one sensor_req rise, overrun=0.
- Invalid command and bad address:
  - Frame {0x07,0x02} → tx 0xEF, 0x00, and sensor_req never asserted.
  - Frame {0x02,0x20} → tx 0xDF, 0x00.
- Timeouts, with SENSOR_TIMEOUT=16 and FRAME_TIMEOUT=16:
  - No sensor_done → sensor_req drops after 16 cycles; tx 0xFE, 0x00.
  - Only the command byte sent, then silence → return to IDLE with no tx_valid.
- Simultaneous events:
  - sensor_done with sensor_error=1 on the timeout cycle → tx 0x1F, 0x00.
  - Third byte arriving during WAIT → overrun=1 and the response is unchanged.
- Backpressure: tx_ready low for 10 cycles in SEND0 → tx_valid stays 1 and tx_data stays stable. Release → both bytes are sent in order, then busy=0.

Source files
------------

// File: rtl/sensor_cmd_controller_if.sv
// Handshake bundle between the command controller and its UART receiver,
// sensor interface and UART transmitter.
interface sensor_cmd_controller_if;
  logic [7:0] rx_data;
  logic       rx_control;
  logic       sensor_req;
  logic [4:0] sensor_addr;
  logic       sensor_done;
  logic       sensor_error;
  logic [7:0] sensor_temp;
  logic [7:0] sensor_hum;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overrun;

  modport slave (
    input  rx_data, rx_control, sensor_done, sensor_error, sensor_temp, sensor_hum, tx_ready,
    output sensor_req, sensor_addr, tx_data, tx_valid, busy, overrun
  );

  modport master (
    output rx_data, rx_control, sensor_done, sensor_error, sensor_temp, sensor_hum, tx_ready,
    input  sensor_req, sensor_addr, tx_data, tx_valid, busy, overrun
  );
endinterface

// File: rtl/sensor_cmd_controller.sv
// Command sequencer: collects {command, address} frames from the receiver,
// runs one sensor transaction per frame and returns a 2-byte response.
module sensor_cmd_controller #(
  parameter int MAX_ADDR       = 31,
  parameter int FRAME_TIMEOUT  = 115200,
  parameter int SENSOR_TIMEOUT = 230400
) (
  input  logic                     clk_115200hz,
  input  logic                     reset,
  sensor_cmd_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    REQ,
    WAIT,
    SEND0,
    SEND1
  } state_t;

  // Timers are 18 bits wide, so SENSOR_TIMEOUT must not exceed 2^18.
  localparam logic [7:0]  MAX_ADDR_B  = 8'(MAX_ADDR);
  localparam logic [17:0] FRAME_LAST  = 18'(FRAME_TIMEOUT - 1);
  localparam logic [17:0] SENSOR_LAST = 18'(SENSOR_TIMEOUT - 1);

  state_t      state;
  logic        rx_control_q;
  logic        rx_pulse;
  logic [7:0]  cmd;
  logic [4:0]  addr;
  logic [7:0]  resp1;
  logic [17:0] frame_timer;
  logic [17:0] sensor_timer;

  assign rx_pulse = bus.rx_control & ~rx_control_q;

  // The first response byte goes straight into tx_data when SEND0 is entered;
  // the second waits in resp1 until the first has been accepted.
  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rx_control_q    <= 1'b0;
      cmd             <= 8'h00;
      addr            <= 5'd0;
      resp1           <= 8'h00;
      frame_timer     <= 18'd0;
      sensor_timer    <= 18'd0;
      bus.sensor_req  <= 1'b0;
      bus.sensor_addr <= 5'd0;
      bus.tx_data     <= 8'h00;
      bus.tx_valid    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      rx_control_q <= bus.rx_control;

      if (rx_pulse && (state == REQ || state == WAIT || state == SEND0 || state == SEND1))
        bus.overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_pulse) begin
            cmd         <= bus.rx_data;
            frame_timer <= 18'd0;
            bus.busy    <= 1'b1;
            state       <= GET_ADDR;
          end
        end

        GET_ADDR: begin
          if (rx_pulse) begin
            addr <= bus.rx_data[4:0];
            if (cmd > 8'h02) begin
              bus.tx_data  <= 8'hEF;
              resp1        <= 8'h00;
              bus.tx_valid <= 1'b1;
              state        <= SEND0;
            end else if (bus.rx_data > MAX_ADDR_B) begin
              bus.tx_data  <= 8'hDF;
              resp1        <= 8'h00;
              bus.tx_valid <= 1'b1;
              state        <= SEND0;
            end else begin
              state <= REQ;
            end
          end else if (frame_timer >= FRAME_LAST) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (frame_timer != '1) begin
            frame_timer <= frame_timer + 18'd1;
          end
        end

        REQ: begin
          bus.sensor_addr <= addr;
          bus.sensor_req  <= 1'b1;
          sensor_timer    <= 18'd0;
          state           <= WAIT;
        end

        // A completion on the timeout cycle still counts as a completion.
        WAIT: begin
          if (bus.sensor_done) begin
            bus.sensor_req <= 1'b0;
            bus.tx_valid   <= 1'b1;
            state          <= SEND0;
            if (bus.sensor_error) begin
              bus.tx_data <= 8'h1F;
              resp1       <= 8'h00;
            end else begin
              case (cmd)
                8'h00: begin
                  bus.tx_data <= 8'h08;
                  resp1       <= 8'h00;
                end
                8'h01: begin
                  bus.tx_data <= 8'h09;
                  resp1       <= bus.sensor_temp;
                end
                8'h02: begin
                  bus.tx_data <= 8'h0A;
                  resp1       <= bus.sensor_hum;
                end
                default: begin
                  bus.tx_data <= 8'hEF;
                  resp1       <= 8'h00;
                end
              endcase
            end
          end else if (sensor_timer >= SENSOR_LAST) begin
            bus.sensor_req <= 1'b0;
            bus.tx_data    <= 8'hFE;
            resp1          <= 8'h00;
            bus.tx_valid   <= 1'b1;
            state          <= SEND0;
          end else if (sensor_timer != '1) begin
            sensor_timer <= sensor_timer + 18'd1;
          end
        end

        SEND0: begin
          if (bus.tx_ready) begin
            bus.tx_data <= resp1;
            state       <= SEND1;
          end
        end

        SEND1: begin
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          bus.sensor_req <= 1'b0;
          bus.tx_valid   <= 1'b0;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_cmd_controller.sv
// Scoreboard bench for sensor_cmd_controller: directed frames push the
// expected response bytes, a negedge monitor pops them on every tx handshake.
module tb_sensor_cmd_controller;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sensor_cmd_controller_if bus();

  sensor_cmd_controller #(
    .MAX_ADDR(31),
    .FRAME_TIMEOUT(16),
    .SENSOR_TIMEOUT(16)
  ) dut (
    .clk_115200hz(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  int req_run = 0;
  int req_last_run = 0;
  int busy_run = 0;
  int busy_last_run = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int hold);
    bus.rx_data    = b;
    bus.rx_control = 1'b1;
    repeat (hold) tick();
    bus.rx_control = 1'b0;
    tick();
  endtask

  task automatic sendFrame(input logic [7:0] c, input logic [7:0] a, input int hold);
    applyStimulus(c, hold);
    applyStimulus(a, hold);
  endtask

  task automatic expectResp(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
  endtask

  task automatic waitReq(input string name);
    int n = 0;
    while (!bus.sensor_req && n < 50) begin
      tick();
      n++;
    end
    checkOutput({name, "_req_seen"}, 32'(bus.sensor_req), 32'd1);
  endtask

  task automatic pulseDone(input logic err, input logic [7:0] temp, input logic [7:0] hum);
    bus.sensor_done  = 1'b1;
    bus.sensor_error = err;
    bus.sensor_temp  = temp;
    bus.sensor_hum   = hum;
    tick();
    bus.sensor_done  = 1'b0;
    bus.sensor_error = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, "_idle"}, 32'(bus.busy == 1'b0 && exp_q.size() == 0), 32'd1);
    repeat (2) tick();
  endtask

  // Monitor: scoreboard pops on each handshake plus run-length bookkeeping.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL tx_unexpected: actual=0x%0h required=no byte", bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("tx_byte", 32'(bus.tx_data), 32'(e));
      end
    end
    if (bus.sensor_req && !req_prev) req_rises++;
    req_prev = bus.sensor_req;
    if (bus.sensor_req) req_run++;
    else if (req_run != 0) begin
      req_last_run = req_run;
      req_run = 0;
    end
    if (bus.busy) busy_run++;
    else if (busy_run != 0) begin
      busy_last_run = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] snap;
    logic stable;
    bus.rx_data      = 8'h00;
    bus.rx_control   = 1'b0;
    bus.sensor_done  = 1'b0;
    bus.sensor_error = 1'b0;
    bus.sensor_temp  = 8'h00;
    bus.sensor_hum   = 8'h00;
    bus.tx_ready     = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy_during", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_req", 32'(bus.sensor_req), 32'd0);
    checkOutput("rst_addr", 32'(bus.sensor_addr), 32'd0);
    checkOutput("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h00);
    checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);

    $display("[TB] temperature read");
    req_rises = 0;
    expectResp(8'h09, 8'h19);
    sendFrame(8'h01, 8'h03, 3);
    waitReq("temp");
    checkOutput("temp_addr", 32'(bus.sensor_addr), 32'd3);
    repeat (2) tick();
    pulseDone(1'b0, 8'h19, 8'h44);
    waitIdle("temp");
    checkOutput("temp_req_rises", 32'(req_rises), 32'd1);
    checkOutput("temp_overrun", 32'(bus.overrun), 32'd0);

    $display("[TB] invalid command");
    req_rises = 0;
    expectResp(8'hEF, 8'h00);
    sendFrame(8'h07, 8'h02, 3);
    waitIdle("badcmd");
    checkOutput("badcmd_no_req", 32'(req_rises), 32'd0);

    $display("[TB] bad address");
    req_rises = 0;
    expectResp(8'hDF, 8'h00);
    sendFrame(8'h02, 8'h20, 3);
    waitIdle("badaddr");
    checkOutput("badaddr_no_req", 32'(req_rises), 32'd0);

    $display("[TB] sensor timeout");
    expectResp(8'hFE, 8'h00);
    sendFrame(8'h01, 8'h05, 3);
    waitReq("stimeout");
    waitIdle("stimeout");
    checkOutput("stimeout_req_len", 32'(req_last_run), 32'd16);

    $display("[TB] frame timeout");
    applyStimulus(8'h01, 3);
    waitIdle("ftimeout");
    checkOutput("ftimeout_busy_len", 32'(busy_last_run), 32'd16);
    checkOutput("ftimeout_tx_valid", 32'(bus.tx_valid), 32'd0);

    $display("[TB] done with error on timeout cycle");
    expectResp(8'h1F, 8'h00);
    sendFrame(8'h01, 8'h06, 1);
    waitReq("doneerr");
    repeat (15) tick();
    pulseDone(1'b1, 8'h55, 8'h66);
    waitIdle("doneerr");

    $display("[TB] overrun during wait");
    expectResp(8'h0A, 8'h37);
    sendFrame(8'h02, 8'h04, 3);
    waitReq("overrun");
    applyStimulus(8'h55, 1);
    checkOutput("overrun_set", 32'(bus.overrun), 32'd1);
    pulseDone(1'b0, 8'h11, 8'h37);
    waitIdle("overrun");
    checkOutput("overrun_sticky", 32'(bus.overrun), 32'd1);

    $display("[TB] backpressure");
    bus.tx_ready = 1'b0;
    expectResp(8'h08, 8'h00);
    sendFrame(8'h00, 8'h01, 2);
    waitReq("bp");
    pulseDone(1'b0, 8'h22, 8'h33);
    checkOutput("bp_valid", 32'(bus.tx_valid), 32'd1);
    snap = bus.tx_data;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.tx_valid || bus.tx_data !== snap) stable = 1'b0;
    end
    checkOutput("bp_stable", 32'(stable), 32'd1);
    checkOutput("bp_data", 32'(snap), 32'h08);
    bus.tx_ready = 1'b1;
    waitIdle("bp");
    checkOutput("bp_busy", 32'(bus.busy), 32'd0);

    $display("[TB] reset mid-wait");
    sendFrame(8'h01, 8'h02, 1);
    waitReq("rstwait");
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("rstwait_req", 32'(bus.sensor_req), 32'd0);
    checkOutput("rstwait_busy", 32'(bus.busy), 32'd0);
    checkOutput("rstwait_tx_valid", 32'(bus.tx_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.busy || bus.tx_valid || bus.sensor_req) stable = 1'b0;
    end
    checkOutput("rstwait_quiet", 32'(stable), 32'd1);
    checkOutput("rstwait_overrun", 32'(bus.overrun), 32'd0);

    $display("[TB] status after reset");
    expectResp(8'h08, 8'h00);
    sendFrame(8'h00, 8'h00, 3);
    waitReq("status");
    pulseDone(1'b0, 8'h01, 8'h02);
    waitIdle("status");

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
